control_path_stall_cpu: RTL

- Decoder and hazard controller for the single-issue MIPS-subset CPU; it is the next generation of the single-bubble control path.
- Decodes opcode/funct into datapath strobes, PC-mux select and ALU opcode.
- On a register hazard, inserts a programmable number of bubble cycles through a counter-driven FSM.
- Adds bne, jal, and/or/slt, and a sticky HALT on illegal opcodes.

---
 rtl/control_path_stall_cpu_if.sv | 42 ++++
 rtl/control_path_stall_cpu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_path_stall_cpu_if.sv
// Decoder/hazard-controller bundle: instruction fields and hazard flags in,
// datapath strobes and stall status out.
interface control_path_stall_cpu_if #(
    parameter int unsigned CNT_W = 3
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             is_alu_zero;
    logic             is_full_rnum1;
    logic             is_full_rnum2;

    logic             is_R_type;
    logic             is_I_type;
    logic             is_J_type;
    logic             is_write_from_mem;
    logic             is_write_reg;
    logic             is_write_mem;
    logic             is_load_PC;
    logic             is_link;
    logic [1:0]       control_mux_for_PC;
    logic [5:0]       opcode_alu;
    logic             is_nop;
    logic             is_previous_nop;
    logic [CNT_W-1:0] stall_count;
    logic             illegal_op;

    // Datapath side: supplies the instruction and hazard flags.
    modport master (
        output opcode, funct, is_alu_zero, is_full_rnum1, is_full_rnum2,
        input  is_R_type, is_I_type, is_J_type, is_write_from_mem, is_write_reg,
        input  is_write_mem, is_load_PC, is_link, control_mux_for_PC, opcode_alu,
        input  is_nop, is_previous_nop, stall_count, illegal_op
    );

    // Controller side.
    modport slave (
        input  opcode, funct, is_alu_zero, is_full_rnum1, is_full_rnum2,
        output is_R_type, is_I_type, is_J_type, is_write_from_mem, is_write_reg,
        output is_write_mem, is_load_PC, is_link, control_mux_for_PC, opcode_alu,
        output is_nop, is_previous_nop, stall_count, illegal_op
    );
endinterface

// File: rtl/control_path_stall_cpu.sv
// Instruction decoder and hazard controller for the single-issue MIPS-subset
// CPU. Inserts STALL_CYCLES bubbles per register hazard and halts on an
// illegal opcode until reset.
module control_path_stall_cpu #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 3,
    parameter int unsigned ENABLE_BNE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    control_path_stall_cpu_if.slave ctrl
);
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpNop   = 6'b111111;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    // WIDTH is carried only for instantiation compatibility.
    if (WIDTH == 0 || STALL_CYCLES == 0 || STALL_CYCLES >= (1 << CNT_W)) begin : g_bad_params
        $error("control_path_stall_cpu: illegal parameter combination");
    end

    typedef enum logic [1:0] {StRun, StStall, StHalt} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             is_previous_nop_q, is_previous_nop_d;

    logic       hz;
    logic       dec_legal, dec_r, dec_i, dec_j, dec_wfm, dec_wreg, dec_wmem, dec_link;
    logic [1:0] dec_pc_sel;
    logic [5:0] dec_alu;

    // rt only matters for instructions that actually read it.
    assign hz = ctrl.is_full_rnum1 |
                (ctrl.is_full_rnum2 & ((ctrl.opcode == OpRType) | (ctrl.opcode == OpSw) |
                                       (ctrl.opcode == OpBeq) | (ctrl.opcode == OpBne)));

    assign ctrl.is_previous_nop = is_previous_nop_q;

    // Pure opcode/funct decode, used only when the cycle is not a bubble.
    always_comb begin
        dec_legal  = 1'b1;
        dec_r      = 1'b0;
        dec_i      = 1'b0;
        dec_j      = 1'b0;
        dec_wfm    = 1'b0;
        dec_wreg   = 1'b0;
        dec_wmem   = 1'b0;
        dec_link   = 1'b0;
        dec_pc_sel = 2'b00;
        dec_alu    = 6'b000000;
        unique case (ctrl.opcode)
            OpRType: begin
                dec_r = 1'b1;
                // Unknown funct executes as a nop rather than trapping.
                unique case (ctrl.funct)
                    FnAdd, FnSub, FnAnd, FnOr, FnSlt: begin
                        dec_alu  = ctrl.funct;
                        dec_wreg = 1'b1;
                    end
                    default: ;
                endcase
            end
            OpAddi: begin
                dec_i    = 1'b1;
                dec_wreg = 1'b1;
                dec_alu  = FnAdd;
            end
            OpLw: begin
                dec_i    = 1'b1;
                dec_wreg = 1'b1;
                dec_wfm  = 1'b1;
                dec_alu  = FnAdd;
            end
            OpSw: begin
                dec_i    = 1'b1;
                dec_wmem = 1'b1;
                dec_alu  = FnAdd;
            end
            OpBeq: begin
                dec_i      = 1'b1;
                dec_alu    = FnSub;
                dec_pc_sel = ctrl.is_alu_zero ? 2'b01 : 2'b00;
            end
            OpBne: begin
                if (ENABLE_BNE != 0) begin
                    dec_i      = 1'b1;
                    dec_alu    = FnSub;
                    dec_pc_sel = ctrl.is_alu_zero ? 2'b00 : 2'b01;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OpJ: begin
                dec_j      = 1'b1;
                dec_pc_sel = 2'b10;
            end
            OpJal: begin
                dec_j      = 1'b1;
                dec_wreg   = 1'b1;
                dec_link   = 1'b1;
                dec_pc_sel = 2'b10;
            end
            OpNop:   ;
            default: dec_legal = 1'b0;
        endcase
    end

    // FSM next state and outputs; everything stays zero while reset is held.
    always_comb begin
        state_d                 = state_q;
        stall_count_d           = stall_count_q;
        is_previous_nop_d       = is_previous_nop_q;
        ctrl.is_R_type          = 1'b0;
        ctrl.is_I_type          = 1'b0;
        ctrl.is_J_type          = 1'b0;
        ctrl.is_write_from_mem  = 1'b0;
        ctrl.is_write_reg       = 1'b0;
        ctrl.is_write_mem       = 1'b0;
        ctrl.is_load_PC         = 1'b0;
        ctrl.is_link            = 1'b0;
        ctrl.control_mux_for_PC = 2'b00;
        ctrl.opcode_alu         = 6'b000000;
        ctrl.is_nop             = 1'b0;
        ctrl.stall_count        = '0;
        ctrl.illegal_op         = 1'b0;
        if (rst) begin
            unique case (state_q)
                StRun: begin
                    // A hazard right after a bubble is ignored so the pipe always advances.
                    if (hz && !is_previous_nop_q) begin
                        ctrl.is_nop       = 1'b1;
                        ctrl.stall_count  = CNT_W'(STALL_CYCLES - 1);
                        is_previous_nop_d = 1'b1;
                        if (STALL_CYCLES > 1) begin
                            stall_count_d = CNT_W'(STALL_CYCLES - 1);
                            state_d       = StStall;
                        end
                    end else if (!dec_legal) begin
                        is_previous_nop_d = 1'b0;
                        state_d           = StHalt;
                    end else begin
                        ctrl.is_R_type          = dec_r;
                        ctrl.is_I_type          = dec_i;
                        ctrl.is_J_type          = dec_j;
                        ctrl.is_write_from_mem  = dec_wfm;
                        ctrl.is_write_reg       = dec_wreg;
                        ctrl.is_write_mem       = dec_wmem;
                        ctrl.is_link            = dec_link;
                        ctrl.control_mux_for_PC = dec_pc_sel;
                        ctrl.opcode_alu         = dec_alu;
                        ctrl.is_load_PC         = 1'b1;
                        is_previous_nop_d       = 1'b0;
                    end
                end
                StStall: begin
                    // Counter holds bubbles remaining including this one.
                    ctrl.is_nop       = 1'b1;
                    ctrl.stall_count  = stall_count_q - CNT_W'(1);
                    stall_count_d     = stall_count_q - CNT_W'(1);
                    is_previous_nop_d = 1'b1;
                    if (stall_count_q == CNT_W'(1)) begin
                        stall_count_d = '0;
                        state_d       = StRun;
                    end
                end
                StHalt: begin
                    ctrl.illegal_op = 1'b1;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // State, counter and bubble-history registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q           <= StRun;
            stall_count_q     <= '0;
            is_previous_nop_q <= 1'b1;
        end else begin
            state_q           <= state_d;
            stall_count_q     <= stall_count_d;
            is_previous_nop_q <= is_previous_nop_d;
        end
    end
endmodule
